// File: rtl/fp_accum_seq.sv
// Streaming accumulator that sequences an external combinational fp_adder:
// each accepted beat folds {acc, beat} through the adder, in_last closes the packet.
module fp_accum_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_flush,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_sub,
  input  logic [31:0]      add_result,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_exc,
  output logic             out_valid,
  input  logic             out_ready
);

  // state | meaning
  // IDLE  | acc cleared, no beat of the current packet seen yet
  // ACCUM | at least one beat folded in, waiting for in_last
  // DONE  | packet closed, result held until out_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] count;
  logic             exc;
  logic             accept;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_count = count;
  assign out_exc   = exc;

  // Subtraction flips the beat's sign so the first beat (a == 0) is already negated.
  assign add_a   = acc;
  assign add_b   = in_sub ? {~in_data[31], in_data[30:0]} : in_data;
  assign add_sub = 1'b0;

  assign accept = in_valid & in_ready & ~in_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 32'h0;
      count <= '0;
      exc   <= 1'b0;
    end else if (in_flush) begin
      state <= IDLE;
      acc   <= 32'h0;
      count <= '0;
      exc   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc   <= add_result;
            if (count != {CNT_W{1'b1}})
              count <= count + CNT_W'(1);
            exc   <= exc | (&in_data[30:23]);
            state <= in_last ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            acc   <= 32'h0;
            count <= '0;
            exc   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Self-checking bench for fp_accum_seq: directed scenarios plus random packets
// compared against a fixed-point reference sum; a small adder stand-in closes the loop.
module tb_fp_accum_seq;
  localparam int CW   = 4;
  localparam int FRAC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in_data;
  logic          in_sub, in_last, in_valid, in_flush;
  logic          in_ready;
  logic [31:0]   add_a, add_b, add_result;
  logic          add_sub;
  logic [31:0]   out_sum;
  logic [CW-1:0] out_count;
  logic          out_exc, out_valid, out_ready;

  int tests = 0;
  int fails = 0;

  fp_accum_seq #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_flush(in_flush),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_result(add_result),
    .out_sum(out_sum), .out_count(out_count), .out_exc(out_exc),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Values are exact multiples of 2^-FRAC, so float <-> fixed conversion is lossless.
  function automatic longint fp_to_fix(logic [31:0] f);
    longint m, mag;
    int e, sh;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    m  = longint'({1'b1, f[22:0]});
    sh = e - 127 + FRAC - 23;
    mag = (sh >= 0) ? (m << sh) : (m >> (-sh));
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] fix_to_fp(longint v);
    longint m, frac;
    int p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 48; i++) if ((m >> i) != 0) p = i;
    frac = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p - FRAC);
    r[22:0]  = frac[22:0];
    return r;
  endfunction

  function automatic logic [31:0] adder_model(logic [31:0] a, logic [31:0] b);
    if ((&a[30:23]) || (&b[30:23])) return 32'h7F80_0000;
    return fix_to_fp(fp_to_fix(a) + fp_to_fix(b));
  endfunction

  always_comb add_result = adder_model(add_a, add_b);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with in_ready high; returns at the following negedge.
  task automatic beat(logic [31:0] d, logic s, logic l);
    chk("in_ready_before_beat", 32'(in_ready), 32'd1);
    in_data = d; in_sub = s; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_sum", out_sum, 32'h0);
    chk("idle_count", 32'(out_count), 32'd0);
  endtask

  task automatic check_result(string tag, logic [31:0] sum, int cnt, logic exc);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_sum"}, out_sum, sum);
    chk({tag, "_count"}, 32'(out_count), 32'(cnt));
    chk({tag, "_exc"}, 32'(out_exc), 32'(exc));
  endtask

  initial begin
    longint exp_fix;
    longint v;
    logic [31:0] sum_hold;
    int n, sat;
    logic s;

    rst = 1'b1; in_data = '0; in_sub = 0; in_last = 0; in_valid = 0;
    in_flush = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", out_sum, 32'h0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_exc", 32'(out_exc), 32'd0);
    chk("add_sub_tied", 32'(add_sub), 32'd0);

    // 1.0 + 2.0
    beat(32'h3F80_0000, 0, 0);
    chk("t1_no_valid_mid", 32'(out_valid), 32'd0);
    beat(32'h4000_0000, 0, 1);
    check_result("t1", 32'h4040_0000, 2, 0);
    consume();

    // single negated beat
    beat(32'h3F80_0000, 1, 1);
    check_result("t2", 32'hBF80_0000, 1, 0);
    consume();

    // 1.5 - 0.5
    beat(32'h3FC0_0000, 0, 0);
    beat(32'h3F00_0000, 1, 1);
    check_result("t3", 32'h3F80_0000, 2, 0);
    sum_hold = out_sum;

    // hold the result under backpressure, in_valid ignored meanwhile
    in_data = 32'h4000_0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_ready", 32'(in_ready), 32'd0);
      chk("t4_hold_sum", out_sum, sum_hold);
      chk("t4_hold_count", 32'(out_count), 32'd2);
    end
    in_valid = 1'b0;
    consume();

    // flush mid-packet with a beat on the same cycle
    beat(32'h3F80_0000, 0, 0);
    beat(32'h3F80_0000, 0, 0);
    in_data = 32'h4000_0000; in_valid = 1'b1; in_flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_flush = 1'b0;
    chk("t5_flush_count", 32'(out_count), 32'd0);
    chk("t5_flush_sum", out_sum, 32'h0);
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    beat(32'h4000_0000, 0, 1);
    check_result("t5", 32'h4000_0000, 1, 0);

    // flush in DONE drops the pending result
    in_flush = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
    chk("t5_done_flush_valid", 32'(out_valid), 32'd0);
    chk("t5_done_flush_sum", out_sum, 32'h0);

    // infinity operand sets sticky exc, then reset mid-packet
    beat(32'h7F80_0000, 0, 0);
    chk("t6_exc_mid", 32'(out_exc), 32'd1);
    beat(32'h3F80_0000, 0, 1);
    check_result("t6", 32'h7F80_0000, 2, 1);
    consume();
    chk("t6_exc_cleared", 32'(out_exc), 32'd0);
    beat(32'h3F80_0000, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_count", 32'(out_count), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_sum", out_sum, 32'h0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);

    // counter saturates at 2^CW-1
    sat = (1 << CW) - 1;
    for (int i = 0; i < sat + 5; i++) beat(32'h3F80_0000, 0, (i == sat + 4));
    check_result("sat", fix_to_fp(longint'(sat + 5) << FRAC), sat, 0);
    consume();

    // random packets against the fixed-point reference sum
    for (int p = 0; p < 16; p++) begin
      n = $urandom_range(1, 8);
      exp_fix = 0;
      for (int i = 0; i < n; i++) begin
        v = longint'($urandom_range(0, 8192)) - 4096;
        s = 1'($urandom_range(0, 1));
        exp_fix += s ? -v : v;
        beat(fix_to_fp(v), s, (i == n - 1));
        if (i != n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      check_result("rand", fix_to_fp(exp_fix), n, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("rand_hold_sum", out_sum, fix_to_fp(exp_fix));
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
